light_pwm_driver: RTL and testbench
===================================

LIGHT_PWM_DRIVER -- requirements
Module: light_pwm_driver

Interface
REQ-001 Parameter PRESCALE, default 4, SHALL set the number of clk cycles per PWM count (legal range 1..255).
REQ-002 Parameter RAMP_DIV, default 16, SHALL set the number of PWM periods per brightness step (legal range 1..255).
REQ-003 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 level  input  4  SHALL be the requested brightness, 0..15, taken from the light controller's light_out.
REQ-006 enable  input  1  SHALL gate the lamp: 1 = follow level, 0 = fade to off.
REQ-007 pwm_out  output  1  SHALL be the registered lamp drive.
REQ-008 cur_level  output  4  SHALL be the current applied brightness.
REQ-009 ramping  output  1  SHALL be 1 while in the UP or DOWN state.
REQ-010 at_target  output  1  SHALL be 1 when cur_level equals the latched target.

Function
REQ-011 Prescaler pre_cnt SHALL count 0..PRESCALE-1 and wrap; tick = (pre_cnt == PRESCALE-1).
REQ-012 pwm_cnt (4 bit) SHALL increment on tick and wrap 15->0; period_end = tick AND pwm_cnt == 15.
REQ-013 The target register SHALL load (enable ? level : 0) only on period_end; level/enable changes between boundaries are ignored until then.
REQ-014 ramp_cnt SHALL count period_end events 0..RAMP_DIV-1 while in UP or DOWN; step = period_end AND ramp_cnt == RAMP_DIV-1.
REQ-015 On step, cur_level SHALL move exactly 1 toward the target; it never wraps and never passes the target.
REQ-016 States SHALL be OFF, UP, DOWN, HOLD; transitions are evaluated only on period_end, using the newly latched target.
REQ-017 OFF: go to UP if target > 0; otherwise stay.
REQ-018 UP/DOWN: if target == cur_level after the step, go to HOLD (or OFF if cur_level == 0); if the target now lies on the opposite side, switch direction without clearing ramp_cnt.
REQ-019 HOLD: go to UP if target > cur_level; go to DOWN if target < cur_level and target > 0 or cur_level > 0; stay otherwise.
REQ-020 ramp_cnt SHALL clear to 0 on entry to HOLD or OFF.
REQ-021 pwm_out SHALL be registered with a 1-cycle latency: pwm_out <= (state != OFF) AND (pwm_cnt < cur_level).
REQ-022 Duty SHALL be cur_level/16; level 15 gives 15 high cycles per 16 counts, and level 0 is constant low.
REQ-023 A simultaneous enable fall and level change SHALL resolve to target 0, because enable has priority.
REQ-024 at_target and ramping SHALL be combinational from registered state only.

Reset
REQ-025 rst_n low SHALL immediately, with no clock, force state OFF and clear pre_cnt, pwm_cnt, ramp_cnt, target, cur_level and pwm_out (all 0); ramping = 0 and at_target = 1.
REQ-026 Reset asserted mid-ramp SHALL discard all progress; after release, operation restarts from OFF on the next period_end.
REQ-027 Reset release SHALL be synchronous to clk for the first count (pre_cnt starts at 0 on the first edge).

Verification (PRESCALE=1 and RAMP_DIV=1 unless stated; period = 16 cycles)
REQ-028 Drive rst_n=0 mid-run with clk stopped -> pwm_out=0, cur_level=0, ramping=0, at_target=1 immediately.
REQ-029 From OFF, set enable=1 and level=4 -> cur_level steps 1,2,3,4 on 4 successive period_ends, then HOLD with at_target=1; pwm_out is high exactly 4 of every 16 cycles.
REQ-030 In HOLD at 15, set level=0 with enable=1 -> 15 down steps, then OFF, and pwm_out stays low.
REQ-031 While ramping up to 12 with cur_level=5, set level=2 -> next step takes cur_level to 4, then 3, then 2, then HOLD; cur_level never exceeds 5.
REQ-032 In HOLD at 7, set enable=0 -> fade 7..0 over 7 periods, then OFF; a level change during the fade has no effect.
REQ-033 With RAMP_DIV=4 and PRESCALE=2, a 0->1 request -> cur_level changes after exactly 4 period_ends (128 cycles) and ramping=1 throughout.

Source files
------------

// File: rtl/light_pwm_driver.sv
// Lamp PWM driver: 16-count PWM whose duty ramps one brightness step at a time
// toward a target latched at PWM period boundaries.
module light_pwm_driver #(
    parameter int PRESCALE = 4,
    parameter int RAMP_DIV = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] level,
    input  logic       enable,
    output logic       pwm_out,
    output logic [3:0] cur_level,
    output logic       ramping,
    output logic       at_target
);

    typedef enum logic [1:0] {OFF, UP, DOWN, HOLD} state_t;

    localparam logic [7:0] PRE_MAX  = 8'(PRESCALE - 1);
    localparam logic [7:0] RAMP_MAX = 8'(RAMP_DIV - 1);

    state_t     state, state_nxt;
    logic [7:0] pre_cnt;
    logic [7:0] ramp_cnt, ramp_cnt_nxt;
    logic [3:0] pwm_cnt;
    logic [3:0] target, target_nxt;
    logic [3:0] cur_nxt;
    logic       tick, period_end, in_ramp, step;

    // One brightness step toward tgt; saturates at the target so it can never overshoot.
    function automatic logic [3:0] step_toward(input logic [3:0] cur, input logic [3:0] tgt);
        if (tgt > cur)
            return cur + 4'd1;
        else if (tgt < cur)
            return cur - 4'd1;
        else
            return cur;
    endfunction

    assign tick       = (pre_cnt == PRE_MAX);
    assign period_end = tick && (pwm_cnt == 4'd15);
    assign target_nxt = enable ? level : 4'd0;
    assign in_ramp    = (state == UP) || (state == DOWN);
    assign step       = period_end && in_ramp && (ramp_cnt == RAMP_MAX);

    assign ramping    = in_ramp;
    assign at_target  = (cur_level == target);

    // Decisions use the target being latched on this same period boundary.
    always_comb begin
        state_nxt    = state;
        ramp_cnt_nxt = ramp_cnt;
        cur_nxt      = cur_level;
        if (period_end) begin
            case (state)
                OFF: begin
                    if (target_nxt != 4'd0)
                        state_nxt = UP;
                end
                UP, DOWN: begin
                    if (step) begin
                        cur_nxt      = step_toward(cur_level, target_nxt);
                        ramp_cnt_nxt = 8'd0;
                    end else begin
                        ramp_cnt_nxt = ramp_cnt + 8'd1;
                    end
                    if (target_nxt == cur_nxt) begin
                        state_nxt    = (cur_nxt == 4'd0) ? OFF : HOLD;
                        ramp_cnt_nxt = 8'd0;
                    end else if (target_nxt > cur_nxt) begin
                        state_nxt = UP;
                    end else begin
                        state_nxt = DOWN;
                    end
                end
                HOLD: begin
                    if (target_nxt > cur_level)
                        state_nxt = UP;
                    else if (target_nxt < cur_level)
                        state_nxt = DOWN;
                end
                default: state_nxt = OFF;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= OFF;
            pre_cnt   <= 8'd0;
            pwm_cnt   <= 4'd0;
            ramp_cnt  <= 8'd0;
            target    <= 4'd0;
            cur_level <= 4'd0;
            pwm_out   <= 1'b0;
        end else begin
            pre_cnt <= tick ? 8'd0 : pre_cnt + 8'd1;
            if (tick)
                pwm_cnt <= pwm_cnt + 4'd1;
            if (period_end)
                target <= target_nxt;
            state     <= state_nxt;
            ramp_cnt  <= ramp_cnt_nxt;
            cur_level <= cur_nxt;
            pwm_out   <= (state != OFF) && (pwm_cnt < cur_level);
        end
    end

endmodule

// File: tb/tb_light_pwm_driver.sv
// Bench for light_pwm_driver: scoreboarded brightness sequences on a fast instance
// (PRESCALE=1, RAMP_DIV=1) and step timing on a slow one (PRESCALE=2, RAMP_DIV=4).
module tb_light_pwm_driver;

    logic       clk = 1'b0;
    logic       clk_run = 1'b1;
    logic       rst_n = 1'b1;
    logic [3:0] level = 4'd0;
    logic       enable = 1'b0;
    logic [3:0] level2 = 4'd0;
    logic       enable2 = 1'b0;

    logic       pwm_out, ramping, at_target;
    logic [3:0] cur_level;
    logic       pwm_out2, ramping2, at_target2;
    logic [3:0] cur_level2;

    int checks = 0;
    int failures = 0;

    logic [3:0] exp_q[$];
    logic [3:0] obs_q[$];
    int         obs_t_q[$];
    int         max_seen;

    always #5 if (clk_run) clk = ~clk;

    light_pwm_driver #(.PRESCALE(1), .RAMP_DIV(1)) dut (
        .clk(clk), .rst_n(rst_n), .level(level), .enable(enable),
        .pwm_out(pwm_out), .cur_level(cur_level), .ramping(ramping), .at_target(at_target)
    );

    light_pwm_driver #(.PRESCALE(2), .RAMP_DIV(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .level(level2), .enable(enable2),
        .pwm_out(pwm_out2), .cur_level(cur_level2), .ramping(ramping2), .at_target(at_target2)
    );

    // Records each change of cur_level with its cycle offset from the call.
    task automatic collect(input int n, input int budget);
        logic [3:0] prev;
        int cyc;
        prev = cur_level;
        cyc = 0;
        max_seen = int'(cur_level);
        obs_q.delete();
        obs_t_q.delete();
        while (obs_q.size() < n && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (int'(cur_level) > max_seen) max_seen = int'(cur_level);
            if (cur_level != prev) begin
                obs_q.push_back(cur_level);
                obs_t_q.push_back(cyc);
                prev = cur_level;
            end
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({pwm_out, cur_level, ramping, at_target} !== {1'b0, 4'd0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL reset_async got pwm=%b cur=%0d ramp=%b at=%b want 0 0 0 1",
                     pwm_out, cur_level, ramping, at_target);
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({pwm_out2, cur_level2, ramping2, at_target2} !== {1'b0, 4'd0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL reset_slow got pwm=%b cur=%0d ramp=%b at=%b want 0 0 0 1",
                     pwm_out2, cur_level2, ramping2, at_target2);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_ramp_up();
        int hi;
        @(negedge clk);
        enable = 1'b1;
        level = 4'd4;
        for (int v = 1; v <= 4; v++) exp_q.push_back(4'(v));
        collect(4, 16 * 8);
        for (int i = 0; exp_q.size() > 0; i++) begin
            logic [3:0] e;
            e = exp_q.pop_front();
            checks++;
            if (i >= obs_q.size()) begin
                failures++;
                $display("FAIL ramp_up_value[%0d] got none want %0d", i, e);
            end else if (obs_q[i] !== e) begin
                failures++;
                $display("FAIL ramp_up_value[%0d] got %0d want %0d", i, obs_q[i], e);
            end
            if (i > 0 && i < obs_t_q.size()) begin
                checks++;
                if (obs_t_q[i] - obs_t_q[i-1] != 16) begin
                    failures++;
                    $display("FAIL ramp_up_interval[%0d] got %0d want 16", i, obs_t_q[i] - obs_t_q[i-1]);
                end
            end
        end
        checks++;
        if ({ramping, at_target} !== 2'b01) begin
            failures++;
            $display("FAIL ramp_up_hold got ramp=%b at=%b want 0 1", ramping, at_target);
        end
        hi = 0;
        repeat (16) begin
            @(negedge clk);
            if (pwm_out) hi++;
        end
        checks++;
        if (hi != 4) begin
            failures++;
            $display("FAIL duty_4 got %0d high want 4", hi);
        end
    endtask

    task automatic test_full_scale();
        int hi;
        level = 4'd15;
        for (int v = 5; v <= 15; v++) exp_q.push_back(4'(v));
        collect(11, 16 * 14);
        for (int i = 0; exp_q.size() > 0; i++) begin
            logic [3:0] e;
            e = exp_q.pop_front();
            checks++;
            if (i >= obs_q.size() || obs_q[i] !== e) begin
                failures++;
                $display("FAIL up_to_15[%0d] got %0d want %0d", i,
                         (i < obs_q.size()) ? int'(obs_q[i]) : -1, e);
            end
        end
        hi = 0;
        repeat (16) begin
            @(negedge clk);
            if (pwm_out) hi++;
        end
        checks++;
        if (hi != 15 || at_target !== 1'b1) begin
            failures++;
            $display("FAIL duty_15 got %0d high at=%b want 15 1", hi, at_target);
        end
        level = 4'd0;
        for (int v = 14; v >= 0; v--) exp_q.push_back(4'(v));
        collect(15, 16 * 18);
        for (int i = 0; exp_q.size() > 0; i++) begin
            logic [3:0] e;
            e = exp_q.pop_front();
            checks++;
            if (i >= obs_q.size() || obs_q[i] !== e) begin
                failures++;
                $display("FAIL down_to_0[%0d] got %0d want %0d", i,
                         (i < obs_q.size()) ? int'(obs_q[i]) : -1, e);
            end
        end
        checks++;
        if ({ramping, at_target} !== 2'b01) begin
            failures++;
            $display("FAIL down_off got ramp=%b at=%b want 0 1", ramping, at_target);
        end
        hi = 0;
        repeat (48) begin
            @(negedge clk);
            if (pwm_out) hi++;
        end
        checks++;
        if (hi != 0) begin
            failures++;
            $display("FAIL off_low got %0d high want 0", hi);
        end
    endtask

    task automatic test_reverse();
        level = 4'd12;
        for (int v = 1; v <= 5; v++) exp_q.push_back(4'(v));
        collect(5, 16 * 8);
        for (int i = 0; exp_q.size() > 0; i++) begin
            logic [3:0] e;
            e = exp_q.pop_front();
            checks++;
            if (i >= obs_q.size() || obs_q[i] !== e) begin
                failures++;
                $display("FAIL rev_up[%0d] got %0d want %0d", i,
                         (i < obs_q.size()) ? int'(obs_q[i]) : -1, e);
            end
        end
        level = 4'd2;
        exp_q.push_back(4'd4);
        exp_q.push_back(4'd3);
        exp_q.push_back(4'd2);
        collect(3, 16 * 6);
        for (int i = 0; exp_q.size() > 0; i++) begin
            logic [3:0] e;
            e = exp_q.pop_front();
            checks++;
            if (i >= obs_q.size() || obs_q[i] !== e) begin
                failures++;
                $display("FAIL rev_down[%0d] got %0d want %0d", i,
                         (i < obs_q.size()) ? int'(obs_q[i]) : -1, e);
            end
        end
        checks++;
        if (max_seen > 5 || ramping !== 1'b0 || at_target !== 1'b1) begin
            failures++;
            $display("FAIL rev_hold got max=%0d ramp=%b at=%b want <=5 0 1", max_seen, ramping, at_target);
        end
    endtask

    task automatic test_fade();
        level = 4'd7;
        for (int v = 3; v <= 7; v++) exp_q.push_back(4'(v));
        collect(5, 16 * 8);
        for (int i = 0; exp_q.size() > 0; i++) begin
            logic [3:0] e;
            e = exp_q.pop_front();
            checks++;
            if (i >= obs_q.size() || obs_q[i] !== e) begin
                failures++;
                $display("FAIL fade_setup[%0d] got %0d want %0d", i,
                         (i < obs_q.size()) ? int'(obs_q[i]) : -1, e);
            end
        end
        enable = 1'b0;
        exp_q.push_back(4'd6);
        exp_q.push_back(4'd5);
        collect(2, 16 * 4);
        for (int i = 0; exp_q.size() > 0; i++) begin
            logic [3:0] e;
            e = exp_q.pop_front();
            checks++;
            if (i >= obs_q.size() || obs_q[i] !== e) begin
                failures++;
                $display("FAIL fade_a[%0d] got %0d want %0d", i,
                         (i < obs_q.size()) ? int'(obs_q[i]) : -1, e);
            end
        end
        level = 4'd11;
        for (int v = 4; v >= 0; v--) exp_q.push_back(4'(v));
        collect(5, 16 * 8);
        for (int i = 0; exp_q.size() > 0; i++) begin
            logic [3:0] e;
            e = exp_q.pop_front();
            checks++;
            if (i >= obs_q.size() || obs_q[i] !== e) begin
                failures++;
                $display("FAIL fade_b[%0d] got %0d want %0d", i,
                         (i < obs_q.size()) ? int'(obs_q[i]) : -1, e);
            end
            if (i > 0 && i < obs_t_q.size()) begin
                checks++;
                if (obs_t_q[i] - obs_t_q[i-1] != 16) begin
                    failures++;
                    $display("FAIL fade_interval[%0d] got %0d want 16", i, obs_t_q[i] - obs_t_q[i-1]);
                end
            end
        end
        checks++;
        if ({ramping, at_target, max_seen > 5} !== 3'b010) begin
            failures++;
            $display("FAIL fade_off got ramp=%b at=%b max=%0d want 0 1 <=5", ramping, at_target, max_seen);
        end
    endtask

    task automatic test_slow_ramp();
        int cyc;
        int drops;
        @(negedge clk);
        enable2 = 1'b1;
        level2 = 4'd1;
        cyc = 0;
        while (ramping2 !== 1'b1 && cyc < 32 * 3) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (ramping2 !== 1'b1) begin
            failures++;
            $display("FAIL slow_start got ramp=%b want 1", ramping2);
        end
        cyc = 0;
        drops = 0;
        while (cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (cur_level2 != 4'd0) break;
            if (ramping2 !== 1'b1) drops++;
        end
        checks++;
        if (cyc != 128 || cur_level2 !== 4'd1) begin
            failures++;
            $display("FAIL slow_step got cycles=%0d cur=%0d want 128 1", cyc, cur_level2);
        end
        checks++;
        if (drops != 0) begin
            failures++;
            $display("FAIL slow_ramping got %0d cycles low want 0", drops);
        end
    endtask

    task automatic test_midramp_reset();
        level = 4'd8;
        enable = 1'b1;
        for (int v = 1; v <= 3; v++) exp_q.push_back(4'(v));
        collect(3, 16 * 6);
        for (int i = 0; exp_q.size() > 0; i++) begin
            logic [3:0] e;
            e = exp_q.pop_front();
            checks++;
            if (i >= obs_q.size() || obs_q[i] !== e) begin
                failures++;
                $display("FAIL mid_up[%0d] got %0d want %0d", i,
                         (i < obs_q.size()) ? int'(obs_q[i]) : -1, e);
            end
        end
        clk_run = 1'b0;
        #12 rst_n = 1'b0;
        #1;
        checks++;
        if ({pwm_out, cur_level, ramping, at_target} !== {1'b0, 4'd0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL stopped_clk_reset got pwm=%b cur=%0d ramp=%b at=%b want 0 0 0 1",
                     pwm_out, cur_level, ramping, at_target);
        end
        checks++;
        if ({cur_level2, ramping2, at_target2} !== {4'd0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL stopped_clk_reset2 got cur=%0d ramp=%b at=%b want 0 0 1",
                     cur_level2, ramping2, at_target2);
        end
        #10 rst_n = 1'b1;
        #4 clk_run = 1'b1;
        exp_q.push_back(4'd1);
        collect(1, 64);
        checks++;
        if (obs_q.size() != 1 || obs_q[0] !== exp_q[0] || obs_t_q[0] != 32) begin
            failures++;
            $display("FAIL restart got n=%0d cur=%0d cyc=%0d want 1 1 32", obs_q.size(),
                     cur_level, (obs_t_q.size() > 0) ? obs_t_q[0] : -1);
        end
        void'(exp_q.pop_front());
    endtask

    initial begin
        test_reset();
        test_ramp_up();
        test_full_scale();
        test_reverse();
        test_fade();
        test_slow_ramp();
        test_midramp_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
